// File: rtl/act_pkg.sv
// act_pkg: shared types and constants for the activation writeback stage
package act_pkg;
  typedef enum logic [1:0] {BYPASS = 2'd0, RELU = 2'd1, GELU = 2'd2} act_mode_e;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} act_state_e;
  localparam logic [4:0] FP16_SAT_EXP = 5'd17;
  localparam logic [15:0] FP16_ZERO = 16'h0000;
endpackage

// File: rtl/act_lane.sv
// act_lane: per-lane LUT address/sign register and S2 result select
module act_lane
  import act_pkg::*;
#(
  parameter int LUT_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_i,
  input  logic              adv_i,
  input  act_mode_e         mode_i,
  input  logic [15:0]       x_i,
  input  logic [15:0]       rdata_i,
  output logic [LUT_AW-1:0] addr_o,
  output logic              sign_o,
  output logic [15:0]       res_o
);
  logic [15:0] x1_q, x2_q, relu;
  logic [LUT_AW-1:0] addr_q;
  logic sign_q, sat;
  always_ff @(posedge clk) begin
    if (rst) begin
      x1_q <= '0;
      x2_q <= '0;
      addr_q <= '0;
      sign_q <= 1'b0;
    end else begin
      if (ld_i) begin
        x1_q <= x_i;
        addr_q <= x_i[14 -: LUT_AW];
        sign_q <= x_i[15];
      end
      if (adv_i) x2_q <= x1_q;
    end
  end
  assign addr_o = addr_q;
  assign sign_o = sign_q;
  // |x| >= 4.0 lies outside the tables, so GELU collapses to ReLU there
  assign sat = x2_q[14:10] >= FP16_SAT_EXP;
  assign relu = x2_q[15] ? FP16_ZERO : x2_q;
  assign res_o = (mode_i == GELU && !sat) ? rdata_i : (mode_i == BYPASS) ? x2_q : relu;
endmodule

// File: rtl/act_lut_stage.sv
// act_lut_stage: activation (bypass/ReLU/GELU LUT) and packed output-SRAM writeback
module act_lut_stage
  import act_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int LUT_AW = 12,
  parameter int OUT_AW = 13
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              cfg_mode,
  input  logic [OUT_AW-1:0]       cfg_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*16-1:0]     in_data,
  output logic [LANES*LUT_AW-1:0] lut_addr,
  output logic [LANES-1:0]        lut_sign,
  input  logic [LANES*16-1:0]     lut_rdata,
  output logic                    wr_en,
  output logic [OUT_AW-1:0]       wr_addr,
  output logic [31:0]             wr_data,
  output logic                    busy,
  output logic                    done
);
  localparam int N = LANES / 2;
  localparam int CW = $clog2(N + 1);
  localparam logic [OUT_AW:0] NW = (OUT_AW + 1)'(N);
  act_state_e state_q, state_d;
  act_mode_e mode_q;
  logic [OUT_AW:0] len_q, issued_q, written_q, written_d, rem;
  logic [OUT_AW-1:0] addr_q;
  logic s1_vld_q, s2_vld_q, hs;
  logic [CW-1:0] s1_cnt_q, s2_cnt_q, ser_cnt_q, vec_cnt;
  logic [LANES*16-1:0] ser_q, res;
  // the last vector of a job may carry fewer than N live words
  assign rem = len_q - issued_q;
  assign vec_cnt = rem < NW ? rem[CW-1:0] : CW'(N);
  assign in_ready = state_q == RUN && !s1_vld_q && !s2_vld_q && ser_cnt_q <= CW'(1) && issued_q < len_q;
  assign hs = in_valid && in_ready;
  assign wr_en = ser_cnt_q != '0;
  assign wr_data = ser_q[31:0];
  assign wr_addr = addr_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign written_d = written_q + {{OUT_AW{1'b0}}, wr_en};
  always_comb begin
    state_d = state_q == IDLE ? (start ? RUN : IDLE) :
              state_q == RUN  ? (written_d == len_q ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q <= BYPASS;
      len_q <= '0;
      issued_q <= '0;
      written_q <= '0;
      addr_q <= '0;
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s1_cnt_q <= '0;
      s2_cnt_q <= '0;
      ser_cnt_q <= '0;
      ser_q <= '0;
    end else begin
      state_q <= state_d;
      s1_vld_q <= hs;
      s2_vld_q <= s1_vld_q;
      s1_cnt_q <= vec_cnt;
      s2_cnt_q <= s1_cnt_q;
      if (state_q == IDLE && start) begin
        mode_q <= cfg_mode == 2'd1 ? RELU : cfg_mode == 2'd2 ? GELU : BYPASS;
        len_q <= {1'b0, cfg_len};
        issued_q <= '0;
        written_q <= '0;
        addr_q <= '0;
      end else begin
        if (hs) issued_q <= issued_q + NW;
        written_q <= written_d;
        if (wr_en) addr_q <= addr_q + 1'b1;
      end
      if (s2_vld_q) begin
        ser_q <= res;
        ser_cnt_q <= s2_cnt_q;
      end else if (wr_en) begin
        ser_q <= ser_q >> 32;
        ser_cnt_q <= ser_cnt_q - 1'b1;
      end
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_lane #(.LUT_AW(LUT_AW)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .ld_i   (hs),
      .adv_i  (s1_vld_q),
      .mode_i (mode_q),
      .x_i    (in_data[16*i +: 16]),
      .rdata_i(lut_rdata[16*i +: 16]),
      .addr_o (lut_addr[LUT_AW*i +: LUT_AW]),
      .sign_o (lut_sign[i]),
      .res_o  (res[16*i +: 16])
    );
  end
endmodule

// File: tb/tb_act_lut_stage.sv
// tb_act_lut_stage: scoreboard bench for act_lut_stage (LANES=4)
module tb_act_lut_stage;
  logic clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [1:0] cfg_mode = 0;
  logic [12:0] cfg_len = 0;
  logic [63:0] in_data = 0;
  logic [47:0] lut_addr;
  logic [3:0] lut_sign;
  logic [63:0] lut_rdata = 0;
  logic in_ready, wr_en, busy, done;
  logic [12:0] wr_addr;
  logic [31:0] wr_data;
  int total = 0, bad = 0, cyc = 0;
  int cur_len = 0, issued_b = 0, wr_count = 0, hs_cnt = 0, last_hs = 0, min_gap = 1000;
  int start_cyc = 0, done_cyc = 0, last_wr = 0;
  logic [1:0] cur_mode = 0;
  logic [12:0] exp_addr = 0;
  logic [12:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [12:0] wa_log[0:127];
  logic [31:0] wd_log[0:127];

  act_lut_stage dut (
    .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .lut_addr(lut_addr), .lut_sign(lut_sign), .lut_rdata(lut_rdata),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] lut_f(input logic [11:0] a, input logic s);
    if (a == 12'h780) return s ? 16'hB11A : 16'h3AB0;
    return s ? {4'hB, a} : {4'h3, a};
  endfunction

  function automatic logic [15:0] exp_lane(input logic [1:0] m, input logic [15:0] x);
    logic [4:0] e;
    e = x[14:10];
    if (m == 2'd2) return (e >= 5'd17) ? (x[15] ? 16'h0000 : x) : lut_f(x[14:3], x[15]);
    if (m == 2'd1) return x[15] ? 16'h0000 : x;
    return x;
  endfunction

  always @(posedge clk)
    for (int i = 0; i < 4; i++) lut_rdata[16*i +: 16] <= lut_f(lut_addr[12*i +: 12], lut_sign[i]);

  always @(negedge clk) begin
    logic [12:0] ea;
    logic [31:0] ed;
    if (in_valid && in_ready) begin
      if (hs_cnt > 0 && cyc - last_hs < min_gap) min_gap = cyc - last_hs;
      last_hs = cyc;
      hs_cnt++;
      for (int k = 0; k < 2; k++)
        if (issued_b < cur_len) begin
          q_addr.push_back(exp_addr);
          q_data.push_back({exp_lane(cur_mode, in_data[32*k+16 +: 16]), exp_lane(cur_mode, in_data[32*k +: 16])});
          exp_addr++;
          issued_b++;
        end
    end
    if (wr_en) begin
      total++;
      if (q_data.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_write got addr=%h data=%h required no write", wr_addr, wr_data);
      end else begin
        ea = q_addr.pop_front();
        ed = q_data.pop_front();
        if (wr_addr !== ea || wr_data !== ed) begin
          bad++;
          $display("FAIL sb_write got addr=%h data=%h required addr=%h data=%h", wr_addr, wr_data, ea, ed);
        end
      end
      if (wr_count < 128) begin
        wa_log[wr_count] = wr_addr;
        wd_log[wr_count] = wr_data;
      end
      wr_count++;
      last_wr = cyc;
    end
  end

  task automatic start_job(input logic [1:0] m, input logic [12:0] l);
    @(posedge clk); #1;
    start = 1; cfg_mode = m; cfg_len = l;
    cur_mode = m; cur_len = int'(l); issued_b = 0; exp_addr = 0;
    wr_count = 0; hs_cnt = 0; min_gap = 1000; start_cyc = cyc;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic send_vec(input logic [63:0] v);
    bit ok = 0;
    in_data = v; in_valid = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL send_vec_timeout got in_ready=0 required 1"); end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_done(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; done_cyc = cyc; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL wait_done_timeout got done=0 required 1"); end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    total++;
    if ({in_ready, wr_en, busy, done} !== 4'b0) begin bad++; $display("FAIL reset_ctrl got %b required 0000", {in_ready, wr_en, busy, done}); end
    total++;
    if ({lut_sign, lut_addr} !== 52'b0) begin bad++; $display("FAIL reset_lut got sign=%b addr=%h required 0", lut_sign, lut_addr); end
    total++;
    if ({wr_addr, wr_data} !== 45'b0) begin bad++; $display("FAIL reset_wr got addr=%h data=%h required 0", wr_addr, wr_data); end
  endtask

  task automatic test_bypass;
    start_job(2'd0, 13'd2);
    send_vec(64'hC000_4000_BC00_3C00);
    wait_done(40);
    total++;
    if (wr_count !== 2 || wd_log[0] !== 32'hBC003C00 || wd_log[1] !== 32'hC0004000) begin
      bad++; $display("FAIL bypass_words got n=%0d w0=%h w1=%h required n=2 w0=bc003c00 w1=c0004000", wr_count, wd_log[0], wd_log[1]);
    end
    total++;
    if (done_cyc !== last_wr + 1) begin bad++; $display("FAIL bypass_done_timing got %0d required %0d", done_cyc, last_wr + 1); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL bypass_idle got busy=%b done=%b required 0 0", busy, done); end
  endtask

  task automatic test_relu;
    start_job(2'd1, 13'd4);
    send_vec(64'hC000_4000_BC00_3C00);
    send_vec(64'h7BFF_FC00_0001_8000);
    wait_done(60);
    total++;
    if (wr_count !== 4 || wd_log[0] !== 32'h00003C00 || wd_log[1] !== 32'h00004000 || wd_log[2] !== 32'h00010000 || wd_log[3] !== 32'h7BFF0000) begin
      bad++; $display("FAIL relu_words got n=%0d %h %h %h %h required 4 00003c00 00004000 00010000 7bff0000", wr_count, wd_log[0], wd_log[1], wd_log[2], wd_log[3]);
    end
  endtask

  task automatic test_gelu;
    start_job(2'd2, 13'd2);
    send_vec(64'hBC00_3C00_C500_4500);
    @(negedge clk);
    total++;
    if (lut_sign !== 4'b1010) begin bad++; $display("FAIL gelu_sign got %b required 1010", lut_sign); end
    total++;
    if (lut_addr[24 +: 12] !== 12'h780 || lut_addr[0 +: 12] !== 12'h8A0) begin bad++; $display("FAIL gelu_addr got %h required lane2=780 lane0=8a0", lut_addr); end
    wait_done(40);
    total++;
    if (wr_count !== 2 || wd_log[0] !== 32'h00004500 || wd_log[1] !== 32'hB11A3AB0) begin
      bad++; $display("FAIL gelu_words got n=%0d w0=%h w1=%h required n=2 w0=00004500 w1=b11a3ab0", wr_count, wd_log[0], wd_log[1]);
    end
  endtask

  task automatic test_len3;
    start_job(2'd0, 13'd3);
    in_data = 64'h4444_3333_2222_1111;
    in_valid = 1;
    wait_done(80);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL len3_ready got %b required 0", in_ready); end
    in_valid = 0;
    total++;
    if (hs_cnt !== 2 || wr_count !== 3) begin bad++; $display("FAIL len3_counts got hs=%0d wr=%0d required hs=2 wr=3", hs_cnt, wr_count); end
    total++;
    if (wd_log[2] !== 32'h22221111 || wa_log[2] !== 13'd2) begin bad++; $display("FAIL len3_last got addr=%h data=%h required 2 22221111", wa_log[2], wd_log[2]); end
  endtask

  task automatic test_len0;
    start_job(2'd0, 13'd0);
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL len0_run got busy=%b ready=%b done=%b required 1 0 0", busy, in_ready, done); end
    wait_done(10);
    total++;
    if (done_cyc !== start_cyc + 2 || wr_count !== 0) begin bad++; $display("FAIL len0_done got cyc=%0d wr=%0d required cyc=%0d wr=0", done_cyc, wr_count, start_cyc + 2); end
  endtask

  task automatic test_back_to_back;
    bit hsn, ok = 0;
    start_job(2'd2, 13'd64);
    in_data = {$urandom, $urandom};
    in_valid = 1'($urandom_range(0, 1));
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
      hsn = in_valid && in_ready;
      @(posedge clk); #1;
      if (hsn) in_data = {$urandom, $urandom};
      in_valid = 1'($urandom_range(0, 1));
    end
    in_valid = 0;
    total++;
    if (!ok) begin bad++; $display("FAIL tput_timeout got done=0 required 1"); end
    total++;
    if (wr_count !== 64 || hs_cnt !== 32) begin bad++; $display("FAIL tput_counts got wr=%0d hs=%0d required 64 32", wr_count, hs_cnt); end
    total++;
    if (min_gap < 4) begin bad++; $display("FAIL tput_spacing got %0d required >=4", min_gap); end
    total++;
    if (wa_log[63] !== 13'd63) begin bad++; $display("FAIL tput_last_addr got %h required 003f", wa_log[63]); end
  endtask

  task automatic test_rst_mid;
    bit ok = 0, seen = 0;
    int wc;
    start_job(2'd0, 13'd4);
    send_vec(64'h0004_0003_0002_0001);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_en) begin ok = 1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL rst_first_write got wr_en=0 required 1"); end
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    q_addr.delete();
    q_data.delete();
    wc = wr_count;
    repeat (20) begin
      @(negedge clk);
      if (wr_en || done) seen = 1;
    end
    total++;
    if (seen || wr_count !== wc || busy !== 1'b0) begin bad++; $display("FAIL rst_quiet got activity=%b busy=%b required 0 0", seen, busy); end
    start_job(2'd0, 13'd2);
    send_vec(64'h0008_0007_0006_0005);
    wait_done(40);
    total++;
    if (wr_count !== 2 || wa_log[0] !== 13'd0 || wd_log[0] !== 32'h00060005) begin
      bad++; $display("FAIL rst_restart got n=%0d addr=%h data=%h required 2 0 00060005", wr_count, wa_log[0], wd_log[0]);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_relu();
    test_gelu();
    test_len3();
    test_len0();
    test_back_to_back();
    test_rst_mid();
    total++;
    if (q_data.size() != 0) begin bad++; $display("FAIL sb_leftover got %0d required 0", q_data.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
